// File: rtl/speck_enc_arbiter.sv
// Two-requester round-robin front end for a single Speck encryption engine.
// One block in flight at a time; a watchdog aborts the transaction if the engine stalls.
module speck_enc_arbiter #(
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_x,
    input  logic [2*W-1:0] req_y,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_x,
    output logic [W-1:0]   rsp_y,
    output logic           rsp_err,
    output logic           eng_start,
    output logic [W-1:0]   eng_pt_x,
    output logic [W-1:0]   eng_pt_y,
    input  logic           eng_done,
    input  logic [W-1:0]   eng_ct_x,
    input  logic [W-1:0]   eng_ct_y,
    output logic           busy,
    output logic           timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    state_t         state_q;
    logic           last_grant_q;
    logic           grant_q;
    logic [15:0]    cnt_q;
    logic [15:0]    cnt_d;
    logic           grant_d;
    logic [1:0]     req_ready_d;
    logic           eng_start_q;
    logic [W-1:0]   eng_pt_x_q;
    logic [W-1:0]   eng_pt_y_q;
    logic [1:0]     rsp_valid_q;
    logic [W-1:0]   rsp_x_q;
    logic [W-1:0]   rsp_y_q;
    logic           rsp_err_q;
    logic           busy_q;
    logic           timeout_err_q;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_d     = req_valid[1];
        req_ready_d = 2'b00;
        if (req_valid == 2'b11) begin
            grant_d = ~last_grant_q;
        end
        if (state_q == S_IDLE && req_valid[grant_d]) begin
            req_ready_d[grant_d] = 1'b1;
        end
    end

    // The counter holds the number of BUSY cycles already elapsed; the abort fires when
    // the next value would hit the limit, so the response lands TIMEOUT cycles after start.
    assign cnt_d = cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            cnt_q         <= '0;
            eng_start_q   <= 1'b0;
            eng_pt_x_q    <= '0;
            eng_pt_y_q    <= '0;
            rsp_valid_q   <= 2'b00;
            rsp_x_q       <= '0;
            rsp_y_q       <= '0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_ready_d[grant_d]) begin
                        eng_pt_x_q  <= grant_d ? req_x[2*W-1:W] : req_x[W-1:0];
                        eng_pt_y_q  <= grant_d ? req_y[2*W-1:W] : req_y[W-1:0];
                        grant_q     <= grant_d;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    if (eng_done) begin
                        rsp_x_q     <= eng_ct_x;
                        rsp_y_q     <= eng_ct_y;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
                        state_q     <= S_RESP;
                    end else if (cnt_d == LIMIT) begin
                        rsp_x_q       <= '0;
                        rsp_y_q       <= '0;
                        rsp_err_q     <= 1'b1;
                        timeout_err_q <= 1'b1;
                        rsp_valid_q   <= grant_q ? 2'b10 : 2'b01;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[grant_q]) begin
                        rsp_valid_q  <= 2'b00;
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_d;
    assign eng_start   = eng_start_q;
    assign eng_pt_x    = eng_pt_x_q;
    assign eng_pt_y    = eng_pt_y_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_x       = rsp_x_q;
    assign rsp_y       = rsp_y_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_speck_enc_arbiter.sv
// Directed bench for speck_enc_arbiter; the bench itself plays the engine,
// returning the known Speck64/128 ciphertext for the reference plaintext.
module tb_speck_enc_arbiter;

    localparam int W       = 32;
    localparam int TIMEOUT = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_x;
    logic [2*W-1:0] req_y;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [W-1:0]   rsp_x;
    logic [W-1:0]   rsp_y;
    logic           rsp_err;
    logic           eng_start;
    logic [W-1:0]   eng_pt_x;
    logic [W-1:0]   eng_pt_y;
    logic           eng_done;
    logic [W-1:0]   eng_ct_x;
    logic [W-1:0]   eng_ct_y;
    logic           busy;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;
    int n_start = 0;

    speck_enc_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_x      (rsp_x),
        .rsp_y      (rsp_y),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_pt_x   (eng_pt_x),
        .eng_pt_y   (eng_pt_y),
        .eng_done   (eng_done),
        .eng_ct_x   (eng_ct_x),
        .eng_ct_y   (eng_ct_y),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (eng_start === 1'b1) n_start <= n_start + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with the bench acting as engine (done after lat BUSY cycles).
    task automatic transact(input int g, input logic [31:0] px, input logic [31:0] py,
                            input logic [31:0] ctx, input logic [31:0] cty,
                            input int lat, input bit drop, input int hold);
        int s0;
        logic [1:0] own;
        own = (g == 1) ? 2'b10 : 2'b01;
        #1;
        chk("req_ready_grant", req_ready, own);
        s0 = n_start;
        tick();
        chk("eng_start_pulse", eng_start, 1);
        chk("eng_pt_x", eng_pt_x, px);
        chk("eng_pt_y", eng_pt_y, py);
        if (drop) begin
            req_valid = 2'b00;
            req_x = ~req_x;
            req_y = ~req_y;
        end
        tick();
        chk("eng_start_low", eng_start, 0);
        chk("eng_pt_x_hold", eng_pt_x, px);
        repeat (lat - 1) tick();
        eng_done = 1'b1;
        eng_ct_x = ctx;
        eng_ct_y = cty;
        tick();
        eng_done = 1'b0;
        chk("rsp_valid", rsp_valid, own);
        chk("rsp_x", rsp_x, ctx);
        chk("rsp_y", rsp_y, cty);
        chk("rsp_err", rsp_err, 0);
        chk("start_count", n_start - s0, 1);
        rsp_ready = ~own;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_rsp_valid", rsp_valid, own);
            chk("bp_rsp_x", rsp_x, ctx);
            chk("bp_rsp_y", rsp_y, cty);
            chk("bp_req_ready", req_ready, 2'b00);
            chk("bp_no_start", n_start - s0, 1);
        end
        rsp_ready = own;
        tick();
        rsp_ready = 2'b00;
        chk("rsp_valid_clear", rsp_valid, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_x = '0;
        req_y = '0;
        eng_done = 1'b0;
        eng_ct_x = '0;
        eng_ct_y = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_eng_pt", {eng_pt_x, eng_pt_y}, 64'h0);
        chk("rst_rsp_data", {rsp_x, rsp_y}, 64'h0);
        chk("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;

        // Reference vector; inputs scrambled after acceptance must not matter.
        req_x = {32'hdeadbeef, 32'h3b726574};
        req_y = {32'h01234567, 32'h7475432d};
        req_valid = 2'b01;
        transact(0, 32'h3b726574, 32'h7475432d, 32'h8c6fa548, 32'h454e028b, 3, 1'b1, 0);
        chk("idle_busy", busy, 0);

        // Stray eng_done while idle.
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("idle_done_rsp_valid", rsp_valid, 2'b00);
        chk("idle_done_busy", busy, 0);

        // Tie from reset: 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_x = {32'h33333333, 32'h11111111};
        req_y = {32'h44444444, 32'h22222222};
        req_valid = 2'b11;
        transact(0, 32'h11111111, 32'h22222222, 32'ha0000001, 32'hb0000001, 1, 1'b0, 0);
        transact(1, 32'h33333333, 32'h44444444, 32'ha0000002, 32'hb0000002, 2, 1'b0, 0);
        transact(0, 32'h11111111, 32'h22222222, 32'ha0000003, 32'hb0000003, 1, 1'b0, 0);
        transact(1, 32'h33333333, 32'h44444444, 32'ha0000004, 32'hb0000004, 3, 1'b0, 0);

        // Backpressure: other requester's ready is asserted but must be ignored.
        transact(0, 32'h11111111, 32'h22222222, 32'hcafef00d, 32'h0badcafe, 2, 1'b0, 10);

        // Done on the last permitted cycle wins over the abort.
        req_valid = 2'b10;
        transact(1, 32'h33333333, 32'h44444444, 32'h12345678, 32'h9abcdef0, TIMEOUT - 1, 1'b0, 0);
        chk("limit_no_timeout_err", timeout_err, 0);

        // Engine never completes.
        req_valid = 2'b01;
        #1;
        chk("to_req_ready", req_ready, 2'b01);
        tick();
        chk("to_eng_start", eng_start, 1);
        req_valid = 2'b00;
        repeat (TIMEOUT - 1) tick();
        chk("to_not_yet", rsp_valid, 2'b00);
        tick();
        chk("to_rsp_valid", rsp_valid, 2'b01);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_data", {rsp_x, rsp_y}, 64'h0);
        chk("to_timeout_err", timeout_err, 1);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("to_rsp_clear", rsp_valid, 2'b00);
        chk("to_sticky", timeout_err, 1);
        req_valid = 2'b10;
        transact(1, 32'h33333333, 32'h44444444, 32'h5a5a5a5a, 32'ha5a5a5a5, 2, 1'b0, 0);
        chk("to_sticky_after", timeout_err, 1);

        // Reset while BUSY with the counter at 5, then a stray done.
        req_valid = 2'b01;
        #1;
        tick();
        chk("mr_eng_start", eng_start, 1);
        req_valid = 2'b00;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_rsp_valid", rsp_valid, 2'b00);
        chk("mr_eng_pt", {eng_pt_x, eng_pt_y}, 64'h0);
        chk("mr_rsp_data", {rsp_x, rsp_y}, 64'h0);
        chk("mr_rsp_err", rsp_err, 0);
        chk("mr_timeout_err", timeout_err, 0);
        chk("mr_eng_start_low", eng_start, 0);
        tick();
        tick();
        eng_done = 1'b1;
        eng_ct_x = 32'hffffffff;
        eng_ct_y = 32'hffffffff;
        tick();
        eng_done = 1'b0;
        chk("mr_stray_rsp_valid", rsp_valid, 2'b00);
        chk("mr_stray_busy", busy, 0);
        chk("mr_stray_rsp_x", rsp_x, 32'h0);
        tick();
        chk("mr_stray_later", rsp_valid, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/speck_enc_arbiter.md
SPECK_ENC_ARBITER -- requirements
Module: speck_enc_arbiter

Interface
REQ-001 Parameter W, default 32, SHALL set the block half-word width (pt_x/pt_y/ct_x/ct_y).
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum cycles from eng_start to eng_done before abort (range 2..65535).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-004 Ports SHALL be exactly as follows (index i = requester 0/1; lane i of each packed bus at [i*W +: W]):
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 req_valid  in  2  requester i has a plaintext block
 req_ready  out  2  block accepts requester i's plaintext this cycle
 req_x  in  2W  plaintext x, per requester
 req_y  in  2W  plaintext y, per requester
 rsp_valid  out  2  ciphertext available for requester i
 rsp_ready  in  2  requester i consumes the response
 rsp_x  out  W  ciphertext x (shared, valid with rsp_valid)
 rsp_y  out  W  ciphertext y (shared, valid with rsp_valid)
 rsp_err  out  1  response is a timeout abort, qualified by rsp_valid
 eng_start  out  1  one-cycle start pulse to speck_encryptor
 eng_pt_x  out  W  plaintext x to engine
 eng_pt_y  out  W  plaintext y to engine
 eng_done  in  1  engine completion
 eng_ct_x  in  W  engine ciphertext x
 eng_ct_y  in  W  engine ciphertext y
 busy  out  1  high in any state other than IDLE
 timeout_err  out  1  sticky: a timeout has occurred since reset

Function
REQ-005 FSM states SHALL be IDLE, START, BUSY, RESP; one transaction in flight at a time.
REQ-006 IDLE: grant g = sole valid requester; if both valid, g = requester other than last_grant (round-robin).
REQ-007 req_ready SHALL be combinational, one-hot on g, only in IDLE and only when req_valid[g]=1; zero in all other states.
REQ-008 On req_valid[g]&req_ready[g], req_x/req_y lane g SHALL be registered into eng_pt_x/eng_pt_y, g stored, next state START.
REQ-009 START: eng_start=1 for exactly this one cycle, cycle counter cleared, next state BUSY; eng_pt_x/eng_pt_y SHALL hold stable from START until return to IDLE.
REQ-010 BUSY: counter increments each cycle; eng_done=1 SHALL capture eng_ct_x/eng_ct_y into rsp_x/rsp_y, rsp_err=0, next state RESP.
REQ-011 BUSY: if eng_done=0 and counter reaches TIMEOUT-1, rsp_x=rsp_y=0, rsp_err=1, timeout_err set, next state RESP; eng_done in the same cycle as the limit SHALL win (normal response).
REQ-012 eng_done outside BUSY SHALL be ignored.
REQ-013 RESP: rsp_valid[g]=1 only (other bit 0), rsp_x/rsp_y/rsp_err stable; on rsp_ready[g]=1, last_grant=g and next state IDLE; rsp_ready[!g] ignored.
REQ-014 Minimum accept-to-accept spacing SHALL be engine latency + 3 cycles (accept, START, done capture, RESP handshake); a request arriving during non-IDLE states waits, req_ready stays 0.
REQ-015 Requester inputs SHALL be sampled only at the accepting handshake; later changes have no effect on the in-flight block.

Reset
REQ-016 rst=1 SHALL force state IDLE, last_grant=1 (requester 0 wins first tie), counter=0, eng_start=0, eng_pt_x=eng_pt_y=0, rsp_valid=0, rsp_x=rsp_y=0, rsp_err=0, timeout_err=0, busy=0.
REQ-017 Reset asserted mid-transaction SHALL abandon it with no response issued; any later eng_done from the engine SHALL be ignored.

Verification
REQ-018 Single request: req0 x=3b726574 y=7475432d, engine with Speck64/128 test key -> one eng_start pulse, rsp_valid=01, rsp_x=8c6fa548, rsp_y=454e028b, rsp_err=0.
REQ-019 Tie: both valid from reset -> req0 served first, then req1; with both continuously valid, grants alternate 0,1,0,1 over four transactions.
REQ-020 Timeout: engine stub never asserts done -> exactly TIMEOUT cycles after eng_start, rsp_valid[g]=1, rsp_err=1, rsp_x=rsp_y=0, timeout_err=1 until rst.
REQ-021 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and data hold stable, req_ready stays 00, no eng_start issued.
REQ-022 Reset mid-BUSY: rst one cycle at counter=5 -> all outputs at reset values next cycle; a stray eng_done 3 cycles later produces no rsp_valid.
